// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states,
// lane widths and the access legality/byte-enable helpers.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int LANES  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } lsu_state_t;

    function automatic logic access_ok(input logic is_store,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        case (f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !is_store;
            default:                legal = 1'b0;
        endcase
        misaligned = ((f3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return legal && !misaligned;
    endfunction

    // Size lives in funct3[1:0] for both loads and stores.
    function automatic logic [LANES-1:0] lane_be(input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Lane extraction and sign/zero extension of a raw memory word for loads.
module lsu_load_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] lane;

    always_comb begin
        lane = raw >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   data = {{(XLEN-BYTE_W){lane[BYTE_W-1]}}, lane[BYTE_W-1:0]};
            F3_LH:   data = {{(XLEN-HALF_W){lane[HALF_W-1]}}, lane[HALF_W-1:0]};
            F3_LBU:  data = {{(XLEN-BYTE_W){1'b0}}, lane[BYTE_W-1:0]};
            F3_LHU:  data = {{(XLEN-HALF_W){1'b0}}, lane[HALF_W-1:0]};
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: validates the access, drives the byte-enabled
// data-memory handshake, stalls the pipeline and registers load results.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [RD_W-1:0] ex_rd,
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [3:0]      dm_be,
    output logic [XLEN-1:0] dm_wdata,
    input  logic [XLEN-1:0] dm_rdata,
    input  logic            dm_ack,
    output logic            stall,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            access_fault
);

    // state  | meaning
    // IDLE   | waiting for a load/store from EX/MEM; faults are reported from here
    // ACCESS | request outstanding on the data-memory port, pipeline stalled

    lsu_state_t state_q, state_d;

    logic            accept;
    logic            fault;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [RD_W-1:0] rd_q;
    logic [XLEN-1:0] load_data;

    always_comb begin
        accept  = (state_q == IDLE) && ex_valid && (ex_mem_read || ex_mem_write);
        fault   = !access_ok(ex_mem_write, ex_funct3, ex_addr[1:0]);
        be_d    = lane_be(ex_funct3[1:0], ex_addr[1:0]);
        wdata_d = '0;
        if (ex_mem_write) begin
            case (ex_funct3)
                F3_SB:   wdata_d = {(XLEN/BYTE_W){ex_store_data[BYTE_W-1:0]}};
                F3_SH:   wdata_d = {(XLEN/HALF_W){ex_store_data[HALF_W-1:0]}};
                default: wdata_d = ex_store_data;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !fault) begin
                    state_d = ACCESS;
                    stall   = 1'b1;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (dm_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .raw     (dm_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .data    (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_be        <= '0;
            dm_wdata     <= '0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            rd_q         <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            access_fault <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            access_fault <= 1'b0;
            if (state_q == IDLE && accept) begin
                if (fault) begin
                    access_fault <= 1'b1;
                end else begin
                    dm_req    <= 1'b1;
                    dm_we     <= ex_mem_write;
                    dm_addr   <= {ex_addr[XLEN-1:2], 2'b00};
                    dm_be     <= be_d;
                    dm_wdata  <= wdata_d;
                    funct3_q  <= ex_funct3;
                    addr_lo_q <= ex_addr[1:0];
                    rd_q      <= ex_rd;
                end
            end else if (state_q == ACCESS && dm_ack) begin
                dm_req <= 1'b0;
                if (!dm_we) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected requests, writebacks and faults are
// queued when an access is driven and retired by a negedge monitor.
module tb_load_store_unit;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data;
    logic [4:0]  ex_rd;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic        stall, wb_valid, access_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   fault_q[$];
    req_t cur_req;
    wb_t  cur_wb;
    logic prev_req = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .access_fault(access_fault)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 :
                            (a == 2'd2) ? 4'b0100 : 4'b1000;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'b001:  return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (dm_req && !prev_req) begin
            if (req_q.size() == 0) begin
                check_val("req_unexpected", 32'd1, 32'd0);
            end else begin
                cur_req = req_q.pop_front();
                check_val("req_we", {31'd0, dm_we}, {31'd0, cur_req.we});
                check_val("req_addr", dm_addr, cur_req.addr);
                check_val("req_be", {28'd0, dm_be}, {28'd0, cur_req.be});
                check_val("req_wdata", dm_wdata, cur_req.wdata);
            end
        end else if (dm_req && prev_req) begin
            check_val("req_hold_addr", dm_addr, cur_req.addr);
            check_val("req_hold_ctl", {27'd0, dm_we, dm_be}, {27'd0, cur_req.we, cur_req.be});
            check_val("req_hold_wdata", dm_wdata, cur_req.wdata);
        end
        prev_req = dm_req;

        if (wb_valid) begin
            check_val("wb_fault_excl", {31'd0, access_fault}, 32'd0);
            if (wb_q.size() == 0) begin
                check_val("wb_unexpected", 32'd1, 32'd0);
            end else begin
                cur_wb = wb_q.pop_front();
                check_val("wb_rd", {27'd0, wb_rd}, {27'd0, cur_wb.rd});
                check_val("wb_data", wb_data, cur_wb.data);
            end
        end

        if (access_fault) begin
            if (fault_q.size() == 0) check_val("fault_unexpected", 32'd1, 32'd0);
            else void'(fault_q.pop_front());
        end
    end

    task automatic do_op(input logic rdf, input logic wrf, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input int ack_dly, input logic exp_fault);
        int stall_cnt;
        req_t r;
        wb_t  w;
        stall_cnt = 0;
        if (exp_fault) begin
            fault_q.push_back(1);
        end else begin
            r.we    = wrf;
            r.addr  = {addr[31:2], 2'b00};
            r.be    = model_be(f3, addr[1:0]);
            r.wdata = wrf ? model_wdata(f3, data) : 32'd0;
            req_q.push_back(r);
            if (!wrf) begin
                w.rd   = rd;
                w.data = model_load(f3, addr[1:0], rdata);
                wb_q.push_back(w);
            end
        end

        @(negedge clk);
        ex_valid      = 1'b1;
        ex_mem_read   = rdf;
        ex_mem_write  = wrf;
        ex_funct3     = f3;
        ex_addr       = addr;
        ex_store_data = data;
        ex_rd         = rd;
        #1;
        if (stall) stall_cnt++;
        @(posedge clk);
        #1;
        ex_valid      = 1'b0;
        ex_addr       = $urandom;
        ex_store_data = $urandom;

        if (exp_fault) begin
            @(negedge clk);
            check_val("fault_no_req", {31'd0, dm_req}, 32'd0);
            check_val("fault_stall", stall_cnt + {31'd0, stall}, 32'd0);
        end else begin
            for (int k = 0; k <= ack_dly; k++) begin
                @(negedge clk);
                if (stall) stall_cnt++;
                if (k == ack_dly) begin
                    dm_ack   = 1'b1;
                    dm_rdata = rdata;
                end
            end
            @(posedge clk);
            #1;
            dm_ack   = 1'b0;
            dm_rdata = $urandom;
            @(negedge clk);
            check_val("done_stall", {31'd0, stall}, 32'd0);
            check_val("done_req", {31'd0, dm_req}, 32'd0);
            check_val("stall_cycles", stall_cnt, ack_dly + 2);
        end
    endtask

    initial begin
        req_t r;
        rst           = 1'b1;
        ex_valid      = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'b000;
        ex_addr       = '0;
        ex_store_data = '0;
        ex_rd         = '0;
        dm_rdata      = '0;
        dm_ack        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ctl", {26'd0, dm_req, dm_we, wb_valid, access_fault, stall, |dm_be}, 32'd0);
        check_val("rst_addr", dm_addr, 32'd0);
        check_val("rst_wdata", dm_wdata, 32'd0);
        check_val("rst_wb", wb_data | {27'd0, wb_rd}, 32'd0);
        rst = 1'b0;

        do_op(1'b0, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0, 5'd0, 0, 1'b0);
        do_op(1'b0, 1'b1, 3'b000, 32'h0D, 32'h000000A5, 32'h0, 5'd0, 2, 1'b0);
        do_op(1'b0, 1'b1, 3'b001, 32'h0A, 32'h1234BEEF, 32'h0, 5'd0, 1, 1'b0);
        do_op(1'b1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 5'd3, 0, 1'b0);
        do_op(1'b1, 1'b0, 3'b000, 32'h03, 32'h0, 32'h80FF1234, 5'd7, 0, 1'b0);
        do_op(1'b1, 1'b0, 3'b100, 32'h03, 32'h0, 32'h80FF1234, 5'd8, 1, 1'b0);
        do_op(1'b1, 1'b0, 3'b001, 32'h06, 32'h0, 32'h80017FFF, 5'd12, 0, 1'b0);
        do_op(1'b1, 1'b0, 3'b101, 32'h06, 32'h0, 32'h80017FFF, 5'd13, 2, 1'b0);
        do_op(1'b1, 1'b0, 3'b010, 32'h04, 32'h0, 32'h80017FFF, 5'd31, 3, 1'b0);
        do_op(1'b1, 1'b0, 3'b000, 32'h01, 32'h0, 32'h00007F00, 5'd4, 0, 1'b0);

        do_op(1'b1, 1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 5'd1, 0, 1'b1);
        do_op(1'b1, 1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 5'd1, 0, 1'b1);
        do_op(1'b0, 1'b1, 3'b001, 32'h01, 32'h1111, 32'h0, 5'd1, 0, 1'b1);
        do_op(1'b0, 1'b1, 3'b100, 32'h00, 32'h2222, 32'h0, 5'd1, 0, 1'b1);

        // A stray ack while idle must not produce anything.
        @(negedge clk);
        dm_ack   = 1'b1;
        dm_rdata = 32'h55AA55AA;
        @(posedge clk);
        #1;
        dm_ack = 1'b0;
        @(negedge clk);
        check_val("idle_ack_req", {31'd0, dm_req}, 32'd0);

        // Reset in the third ACCESS cycle; the late ack must be dropped.
        r.we = 1'b0; r.addr = 32'h10; r.be = 4'b1111; r.wdata = 32'd0;
        req_q.push_back(r);
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_funct3 = 3'b010; ex_addr = 32'h10; ex_rd = 5'd6;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_mid_req", {31'd0, dm_req}, 32'd0);
        check_val("rst_mid_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        dm_ack   = 1'b1;
        dm_rdata = 32'h12345678;
        @(posedge clk);
        #1;
        dm_ack = 1'b0;
        @(negedge clk);
        check_val("late_ack_wb", {31'd0, wb_valid}, 32'd0);

        do_op(1'b1, 1'b0, 3'b010, 32'h00, 32'h0, 32'h13579BDF, 5'd9, 1, 1'b0);

        repeat (3) @(negedge clk);
        check_val("req_q_left", req_q.size(), 32'd0);
        check_val("wb_q_left", wb_q.size(), 32'd0);
        check_val("fault_q_left", fault_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage access controller sitting directly upstream of the data memory in the pipelined RISC-V core. It accepts a load/store from the EX/MEM register and validates alignment and funct3. It then drives a word-addressed, byte-enabled request/ack interface to the memory, stalling the pipeline until the access completes. Loads are lane-extracted and sign/zero-extended, and the result is registered for the MEM/WB path.

Parameters:
XLEN, 32, data/address width
RD_W, 5, destination register index width

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
ex_valid  input  1  EX/MEM holds a valid instruction
ex_mem_read  input  1  instruction is a load
ex_mem_write  input  1  instruction is a store
ex_funct3  input  3  RISC-V funct3 (size/sign)
ex_addr  input  XLEN  effective byte address
ex_store_data  input  XLEN  rs2 value (unshifted)
ex_rd  input  RD_W  load destination register
dm_req  output  1  memory request valid
dm_we  output  1  1 = write, 0 = read
dm_addr  output  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
dm_be  output  4  byte enables
dm_wdata  output  XLEN  lane-replicated store data
dm_rdata  input  XLEN  raw word from memory, valid with dm_ack
dm_ack  input  1  access complete (one cycle)
stall  output  1  hold IF..EX/MEM stages
wb_valid  output  1  load result valid (one-cycle pulse)
wb_rd  output  RD_W  load destination
wb_data  output  XLEN  extended load data
access_fault  output  1  misaligned or illegal funct3 (one-cycle pulse)

Behaviour:
- Reset: state IDLE; dm_req, dm_we, dm_be, wb_valid, access_fault = 0; dm_addr, dm_wdata, wb_rd, wb_data = 0.
- States: IDLE, ACCESS.
- Accept condition, in IDLE: ex_valid && (ex_mem_read || ex_mem_write).
- Read and write both set: treated as a store (write wins).
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Fault check on accept: a funct3 outside the legal set, a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - On fault: access_fault=1 on the next cycle; no request, no wb_valid, stall never asserted; remain in IDLE.
- Legal accept:
  - stall=1 combinationally in the accept cycle.
  - At the edge: latch request fields, set dm_req=1, move to ACCESS.
- ACCESS:
  - dm_req, dm_we, dm_addr, dm_be, dm_wdata are held stable; stall=1.
  - On dm_ack: dm_req is cleared at the edge and the unit returns to IDLE; stall drops in the following cycle.
  - If the access is a load: wb_valid=1, wb_rd, wb_data are registered from dm_rdata at that same edge.
- Store formatting:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111; wdata = data.
- Load formatting: lane = dm_rdata >> (8*addr[1:0]); LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- Read requests drive dm_be with the access lanes and dm_wdata = 0.
- Minimum latency: accept in cycle N, dm_req in N+1, ack earliest in N+1, wb_valid in N+2. The stall asserted in N masks the next instruction.
- Ignored events:
  - dm_ack while in IDLE.
  - ex_* changes while in ACCESS (upstream holds; the unit uses latched values).
- Reset mid-ACCESS: the next edge returns to IDLE with dm_req=0; a late ack is ignored; no wb_valid.
- wb_valid and access_fault are never high in the same cycle.

Decomposition:
- Shared defines header: funct3 codes (LB..LHU, SB..SW), state encodings, byte-lane widths.
- One combinational sub-module, lsu_load_align: inputs raw word, addr[1:0], funct3; output extended data. Reused by any future cache path.
- Store formatting, FSM, and registers stay in load_store_unit.

Test Plan:
- SW addr 0x08, data 0xDEADBEEF, ack 1 cycle after req -> dm_addr 0x08, dm_be 1111, dm_wdata 0xDEADBEEF, dm_we 1; stall high 2 cycles; no wb_valid.
- SB addr 0x0D, data 0x000000A5 -> dm_addr 0x0C, dm_be 0010, dm_wdata 0xA5A5A5A5.
- LB addr 0x03, dm_rdata 0x80FF1234 -> wb_data 0xFFFFFF80; LBU same address -> 0x00000080; wb_rd matches ex_rd; wb_valid a single pulse.
- LH addr 0x06, dm_rdata 0x80017FFF -> wb_data 0xFFFF8001; LHU -> 0x00008001; LW addr 0x04 -> 0x80017FFF.
- LW addr 0x02, then funct3 011 with a load -> access_fault pulse for each, dm_req never asserted, stall stays 0.
- LW with ack withheld 5 cycles and rst pulsed in the 3rd ACCESS cycle -> dm_req 0 next cycle, no wb_valid even when ack arrives. A following LW addr 0x00 completes normally.
